// File: rtl/fs_wbuf_ctrl.sv
// Write-side frame buffer controller: picks the next DDR buffer on each frame start,
// flushes the write FIFO, then streams fixed-size FDMA bursts until a frame is stored.
module fs_wbuf_ctrl #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 'h0100_0000,
  parameter logic [ADDR_W-1:0] BUF_SIZE     = 'h0080_0000,
  parameter int                BUF_NUM      = 3,
  parameter int                BUF_W        = 2,
  parameter int                DATA_BYTES   = 16,
  parameter int                BURST_LEN    = 256,
  parameter int                FRAME_BURSTS = 2025,
  parameter int                FIFO_CNT_W   = 10,
  parameter int                FLUSH_CYC    = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  fs_i,
  input  logic [BUF_W-1:0]      rbuf_idx_i,
  input  logic [FIFO_CNT_W-1:0] fifo_rcnt_i,
  input  logic                  fdma_wbusy_i,
  output logic                  fdma_wareq_o,
  output logic [ADDR_W-1:0]     fdma_waddr_o,
  output logic [15:0]           fdma_wsize_o,
  output logic                  fifo_rst_o,
  output logic [BUF_W-1:0]      wbuf_idx_o,
  output logic                  frame_done_o,
  output logic                  frame_ovf_o
);

  localparam int                FC_W        = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * DATA_BYTES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_WAIT  = 3'd2,
    S_REQ   = 3'd3,
    S_BUSY  = 3'd4
  } state_t;

  state_t            r_state, w_nxt_state;
  logic [BUF_W-1:0]  r_wbuf, w_nxt_wbuf;
  logic [15:0]       r_burst_cnt, w_nxt_cnt;
  logic              r_pend_fs, w_nxt_pend;
  logic [FC_W-1:0]   r_flush_cnt, w_nxt_fcnt;
  logic [ADDR_W-1:0] r_waddr, w_nxt_addr;
  logic              r_done, w_nxt_done;
  logic              r_ovf, w_nxt_ovf;

  logic [BUF_W-1:0]  w_adv;
  logic [15:0]       w_cnt_inc;
  logic [ADDR_W-1:0] w_req_addr;

  // Next buffer after w, stepping over the one the reader holds when a spare exists.
  function automatic logic [BUF_W-1:0] f_adv(input logic [BUF_W-1:0] w,
                                             input logic [BUF_W-1:0] r);
    int unsigned n;
    n = (32'(w) + 32'd1) % 32'(BUF_NUM);
    if (BUF_NUM > 2 && n == 32'(r))
      n = (32'(w) + 32'd2) % 32'(BUF_NUM);
    return BUF_W'(n);
  endfunction

  assign w_adv      = f_adv(r_wbuf, rbuf_idx_i);
  assign w_cnt_inc  = r_burst_cnt + 16'd1;
  assign w_req_addr = BASE_ADDR + ADDR_W'(r_wbuf) * BUF_SIZE
                    + ADDR_W'(r_burst_cnt) * BURST_BYTES;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= S_IDLE;
      r_wbuf      <= BUF_W'(BUF_NUM - 1);
      r_burst_cnt <= '0;
      r_pend_fs   <= 1'b0;
      r_flush_cnt <= '0;
      r_waddr     <= '0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_wbuf      <= w_nxt_wbuf;
      r_burst_cnt <= w_nxt_cnt;
      r_pend_fs   <= w_nxt_pend;
      r_flush_cnt <= w_nxt_fcnt;
      r_waddr     <= w_nxt_addr;
      r_done      <= w_nxt_done;
      r_ovf       <= w_nxt_ovf;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_wbuf  = r_wbuf;
    w_nxt_cnt   = r_burst_cnt;
    w_nxt_pend  = r_pend_fs;
    w_nxt_fcnt  = r_flush_cnt;
    w_nxt_addr  = r_waddr;
    w_nxt_done  = 1'b0;
    w_nxt_ovf   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (fs_i) begin
          w_nxt_state = S_FLUSH;
          w_nxt_wbuf  = w_adv;
          w_nxt_cnt   = '0;
          w_nxt_fcnt  = '0;
          w_nxt_pend  = 1'b0;
        end
      end
      S_FLUSH: begin
        if (fs_i) begin
          w_nxt_ovf  = 1'b1;
          w_nxt_wbuf = w_adv;
          w_nxt_cnt  = '0;
          w_nxt_fcnt = '0;
        end else if (r_flush_cnt == FC_W'(FLUSH_CYC - 1)) begin
          w_nxt_state = S_WAIT;
        end else begin
          w_nxt_fcnt = r_flush_cnt + FC_W'(1);
        end
      end
      S_WAIT: begin
        if (fs_i) begin
          w_nxt_state = S_FLUSH;
          w_nxt_ovf   = 1'b1;
          w_nxt_wbuf  = w_adv;
          w_nxt_cnt   = '0;
          w_nxt_fcnt  = '0;
          w_nxt_pend  = 1'b0;
        end else if (fifo_rcnt_i >= FIFO_CNT_W'(BURST_LEN) && !fdma_wbusy_i) begin
          w_nxt_state = S_REQ;
          w_nxt_addr  = w_req_addr;
        end
      end
      S_REQ: begin
        if (fs_i) w_nxt_pend = 1'b1;
        if (fdma_wbusy_i) w_nxt_state = S_BUSY;
      end
      S_BUSY: begin
        if (fs_i) w_nxt_pend = 1'b1;
        if (!fdma_wbusy_i) begin
          w_nxt_cnt = w_cnt_inc;
          // A frame start seen during the burst is honoured only once the burst lands.
          if (r_pend_fs || fs_i) begin
            w_nxt_state = S_FLUSH;
            w_nxt_ovf   = 1'b1;
            w_nxt_wbuf  = w_adv;
            w_nxt_cnt   = '0;
            w_nxt_fcnt  = '0;
            w_nxt_pend  = 1'b0;
          end else if (w_cnt_inc == 16'(FRAME_BURSTS)) begin
            w_nxt_state = S_IDLE;
            w_nxt_done  = 1'b1;
          end else begin
            w_nxt_state = S_WAIT;
          end
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  assign fdma_wareq_o = (r_state == S_REQ);
  assign fdma_waddr_o = r_waddr;
  assign fdma_wsize_o = 16'(BURST_LEN);
  assign fifo_rst_o   = (r_state == S_FLUSH);
  assign wbuf_idx_o   = r_wbuf;
  assign frame_done_o = r_done;
  assign frame_ovf_o  = r_ovf;

endmodule

// File: tb/tb_fs_wbuf_ctrl.sv
// Bench for fs_wbuf_ctrl: cycle reference model plus directed and randomized frames.
module tb_fs_wbuf_ctrl;
  localparam int          FB   = 4;
  localparam int          BN   = 3;
  localparam int          FL   = 8;
  localparam int          BL   = 256;
  localparam int          DB   = 16;
  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam logic [31:0] BSZ  = 32'h0080_0000;

  logic        clk = 1'b0, rstn = 1'b0, fs = 1'b0, wbusy = 1'b0;
  logic [1:0]  rbuf = 2'd0;
  logic [9:0]  rcnt = 10'd0;
  logic        wareq, fifo_rst, done, ovf;
  logic [31:0] waddr;
  logic [15:0] wsize;
  logic [1:0]  wbuf;

  fs_wbuf_ctrl #(.FRAME_BURSTS(FB)) dut (
    .clk_i(clk), .rstn_i(rstn), .fs_i(fs), .rbuf_idx_i(rbuf), .fifo_rcnt_i(rcnt),
    .fdma_wbusy_i(wbusy), .fdma_wareq_o(wareq), .fdma_waddr_o(waddr),
    .fdma_wsize_o(wsize), .fifo_rst_o(fifo_rst), .wbuf_idx_o(wbuf),
    .frame_done_o(done), .frame_ovf_o(ovf)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference model: frame/burst bookkeeping in plain integers.
  int m_idx, m_flush, m_bursts;
  bit m_idle, m_req, m_busy, m_pend, m_done, m_ovf;

  function automatic int adv(input int w, input int r);
    int n;
    n = (w + 1) % BN;
    if (BN > 2 && n == r) n = (w + 2) % BN;
    return n;
  endfunction

  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      m_idx = BN - 1; m_flush = 0; m_bursts = 0;
      m_idle = 1; m_req = 0; m_busy = 0; m_pend = 0; m_done = 0; m_ovf = 0;
    end else begin
      m_done = 0; m_ovf = 0;
      if (m_idle) begin
        if (fs) begin m_idx = adv(m_idx, rbuf); m_bursts = 0; m_flush = FL; m_idle = 0; end
      end else if (m_flush > 0) begin
        if (fs) begin m_ovf = 1; m_idx = adv(m_idx, rbuf); m_bursts = 0; m_flush = FL; end
        else m_flush--;
      end else if (m_req) begin
        if (fs) m_pend = 1;
        if (wbusy) begin m_req = 0; m_busy = 1; end
      end else if (m_busy) begin
        if (fs) m_pend = 1;
        if (!wbusy) begin
          m_busy = 0;
          m_bursts++;
          if (m_pend) begin
            m_ovf = 1; m_idx = adv(m_idx, rbuf); m_bursts = 0; m_flush = FL; m_pend = 0;
          end else if (m_bursts == FB) begin
            m_done = 1; m_idle = 1;
          end
        end
      end else begin
        if (fs) begin m_ovf = 1; m_idx = adv(m_idx, rbuf); m_bursts = 0; m_flush = FL; end
        else if (rcnt >= BL && !wbusy) m_req = 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (rstn) begin
      chk("wbuf_idx", wbuf, 64'(m_idx));
      chk("fifo_rst", fifo_rst, 64'(!m_idle && m_flush > 0));
      chk("wareq", wareq, 64'(m_req));
      if (m_req) chk("waddr", waddr, 64'(BASE + 32'(m_idx) * BSZ + 32'(m_bursts * BL * DB)));
      chk("wsize", wsize, 64'(BL));
      chk("frame_done", done, 64'(m_done));
      chk("frame_ovf", ovf, 64'(m_ovf));
    end
  end

  // Event recorder.
  logic [31:0] req_q[$];
  int done_seen = 0, ovf_seen = 0;
  logic prev_req = 1'b0;
  initial forever begin
    @(negedge clk);
    if (rstn) begin
      if (wareq && !prev_req) req_q.push_back(waddr);
      if (done) done_seen++;
      if (ovf) ovf_seen++;
    end
    prev_req = wareq;
  end

  // FDMA responder: busy window after a request.
  bit resp_en = 1;
  int dmin = 0, dmax = 0, bmin = 20, bmax = 20;
  initial forever begin
    tick();
    if (!rstn) wbusy = 1'b0;
    else if (resp_en && wareq && !wbusy) begin
      repeat ($urandom_range(dmin, dmax)) tick();
      if (rstn) begin
        wbusy = 1'b1;
        repeat ($urandom_range(bmin, bmax)) tick();
        wbusy = 1'b0;
      end
    end
  end

  task automatic pulse_fs(input logic [1:0] rb);
    rbuf = rb; fs = 1'b1; tick(); fs = 1'b0;
  endtask

  logic [31:0] exp_addr[4];
  int n, q0, o0;
  bit hit;

  initial begin
    exp_addr[0] = 32'h0100_0000; exp_addr[1] = 32'h0100_1000;
    exp_addr[2] = 32'h0100_2000; exp_addr[3] = 32'h0100_3000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wbuf", wbuf, 2); chk("rst_wareq", wareq, 0); chk("rst_fifo_rst", fifo_rst, 0);
    chk("rst_done", done, 0); chk("rst_ovf", ovf, 0); chk("rst_waddr", waddr, 0);
    chk("rst_wsize", wsize, 256);
    tick(); rstn = 1'b1; tick();

    // First frame start: index 2 -> 0, flush for 8 cycles.
    pulse_fs(2'd2);
    chk("fs1_wbuf", wbuf, 0);
    n = 0;
    repeat (20) begin if (fifo_rst) n++; tick(); end
    chk("flush_len", n, 8);

    // Full frame of 4 bursts at consecutive 4 KiB offsets.
    rcnt = 10'd256;
    hit = 0;
    for (int i = 0; i < 1000 && !hit; i++) begin tick(); hit = (done_seen != 0); end
    chk("frame_done_timeout", hit, 1);
    repeat (5) tick();
    chk("req_count", req_q.size(), 4);
    for (int i = 0; i < 4 && i < req_q.size(); i++) chk("req_addr", req_q[i], exp_addr[i]);
    chk("done_once", done_seen, 1);

    // Index rotation with the reader-skip rule.
    rcnt = 10'd255;
    pulse_fs(2'd1); chk("rot0_wbuf", wbuf, 2); tick();
    pulse_fs(2'd0); chk("rot1_wbuf", wbuf, 1); tick();
    pulse_fs(2'd2); chk("rot2_wbuf", wbuf, 0); tick();
    pulse_fs(2'd0); chk("rot3_wbuf", wbuf, 1);

    // FIFO threshold: 255 holds off, 256 requests next cycle with stable address.
    repeat (20) tick();
    for (int i = 0; i < 5; i++) begin chk("no_req_255", wareq, 0); tick(); end
    dmin = 3; dmax = 3;
    rcnt = 10'd256; tick();
    chk("req_at_256", wareq, 1);
    for (int i = 0; i < 3; i++) begin chk("waddr_stable", waddr, 32'h0180_0000); tick(); end

    // Frame start in the middle of burst 2 of this frame.
    q0 = req_q.size(); o0 = ovf_seen;
    hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin tick(); hit = (req_q.size() >= q0 + 1 && wbusy); end
    chk("burst2_busy_timeout", hit, 1);
    repeat (5) tick();
    pulse_fs(2'd0);
    chk("pend_no_ovf_yet", ovf, 0);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin @(negedge clk); hit = ovf; end
    chk("ovf_timeout", hit, 1);
    chk("ovf_wbusy_done", wbusy, 0);
    chk("ovf_fifo_rst", fifo_rst, 1);
    chk("ovf_wbuf", wbuf, 2);
    repeat (5) tick();
    chk("ovf_once", ovf_seen - o0, 1);

    // Randomized traffic.
    dmin = 0; dmax = 4; bmin = 1; bmax = 12;
    n = done_seen;
    for (int i = 0; i < 4000; i++) begin
      fs = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) rbuf = 2'($urandom_range(0, BN - 1));
      rcnt = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 255)) : 10'($urandom_range(256, 1023));
      tick();
    end
    fs = 1'b0;
    chk("random_frames_done", done_seen > n, 1);

    // Async reset while a request is outstanding.
    resp_en = 0; rcnt = 10'd256;
    repeat (30) tick();
    if (!wareq) pulse_fs(2'd0);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin tick(); hit = wareq; end
    chk("req_before_reset", hit, 1);
    @(negedge clk); #2 rstn = 1'b0; #1;
    chk("arst_wareq", wareq, 0); chk("arst_fifo_rst", fifo_rst, 0); chk("arst_wbuf", wbuf, 2);
    chk("arst_waddr", waddr, 0); chk("arst_done", done, 0); chk("arst_ovf", ovf, 0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
